dp_ram_ctrl: RTL and testbench

- Parametrised simple-dual-port RAM: one write port, one read port, each with a valid/ready handshake.
- Extends the team's single-port memory with:
  - byte-enable writes
  - configurable read latency
  - defined read-during-write behaviour
  - out-of-range address detection
  - a hardware zero-initialisation sweep after reset
- Used as the local buffer behind bus slaves and DMA engines.

---
 rtl/dp_ram_ctrl.sv | 141 ++++++++++++++
 tb/tb_dp_ram_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_ctrl.sv
// Simple-dual-port RAM with valid/ready ports, byte-enable writes,
// 1- or 2-cycle read latency, selectable read-during-write behaviour,
// out-of-range address flagging and a zero-fill sweep after reset.
module dp_ram_ctrl #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned DEPTH        = 64,
   parameter int unsigned ADDR_WIDTH   = $clog2(DEPTH),
   parameter int unsigned BE_WIDTH     = WIDTH / 8,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned RDW_MODE     = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  init_done,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [BE_WIDTH-1:0]   wr_be,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  rd_data_valid,
   output logic                  addr_err
);

   typedef enum logic {INIT, RUN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [WIDTH-1:0]      mem [DEPTH];

   logic                  wr_acc;
   logic                  rd_acc;
   logic                  wr_in;
   logic                  rd_in;
   logic [WIDTH-1:0]      rd_word;
   logic                  s1_valid;
   logic [WIDTH-1:0]      s1_data;

   // Accept qualification; ready flags are registered and lag rst by one
   // edge, so rst itself also blocks acceptance.
   always_comb begin
      wr_in  = 32'(wr_addr) < DEPTH;
      rd_in  = 32'(rd_addr) < DEPTH;
      wr_acc = wr_valid && wr_ready && !rst;
      rd_acc = rd_valid && rd_ready && !rst;
   end

   // Read word at accept time, with same-address write bytes folded in for write-first mode
   always_comb begin
      rd_word = '0;
      if (rd_in) begin
         rd_word = mem[rd_addr];
         if (RDW_MODE == 0 && wr_acc && wr_in && wr_addr == rd_addr) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
               if (wr_be[i]) begin
                  rd_word[8*i +: 8] = wr_data[8*i +: 8];
               end
            end
         end
      end
   end

   // Control FSM: zero-fill sweep one word per cycle, then run with constant ready
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         cnt       <= '0;
         init_done <= 1'b0;
         wr_ready  <= 1'b0;
         rd_ready  <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               if (32'(cnt) == DEPTH - 1) begin
                  state     <= RUN;
                  init_done <= 1'b1;
                  wr_ready  <= 1'b1;
                  rd_ready  <= 1'b1;
               end else begin
                  cnt <= cnt + ADDR_WIDTH'(1);
               end
            end
            RUN: begin
               init_done <= 1'b1;
               wr_ready  <= 1'b1;
               rd_ready  <= 1'b1;
            end
            default: state <= INIT;
         endcase
      end
   end

   // Memory array: sweep writes during INIT, byte-enabled in-range writes in RUN
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            mem[cnt] <= '0;
         end else if (wr_acc && wr_in) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
               if (wr_be[i]) begin
                  mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
               end
            end
         end
      end
   end

   // Read pipeline and error pulse; data is captured at accept so a later
   // write cannot alter an in-flight read.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid      <= 1'b0;
         s1_data       <= '0;
         rd_data_valid <= 1'b0;
         rd_data       <= '0;
         addr_err      <= 1'b0;
      end else begin
         addr_err <= (wr_acc && !wr_in) || (rd_acc && !rd_in);
         if (READ_LATENCY == 2) begin
            s1_valid <= rd_acc;
            if (rd_acc) begin
               s1_data <= rd_word;
            end
            rd_data_valid <= s1_valid;
            if (s1_valid) begin
               rd_data <= s1_data;
            end
         end else begin
            s1_valid      <= 1'b0;
            rd_data_valid <= rd_acc;
            if (rd_acc) begin
               rd_data <= rd_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Scoreboard bench for dp_ram_ctrl: three configurations share one stimulus
// stream; each has its own reference model, expectation queues and monitor.
module tb_dp_ram_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rd_valid;
   logic [5:0]  rd_addr;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   typedef struct {
      int unsigned cyc;
      logic [31:0] data;
   } exp_t;

   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old_w,
                                         input logic [31:0] new_w,
                                         input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

   task automatic chk(input int unsigned c, input string name,
                      input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s cfg%0d t=%0t: got %h expected %h", name, c, $time, act, exp);
      end
   endtask

   // cfg0: DEPTH 48, latency 2, write-first; cfg1: 64, latency 1, read-first;
   // cfg2: 64, latency 1, write-first
   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int unsigned D = (g == 0) ? 48 : 64;
      localparam int unsigned L = (g == 0) ? 2 : 1;
      localparam int unsigned M = (g == 1) ? 1 : 0;

      logic        init_done, wr_ready, rd_ready, rd_data_valid, addr_err;
      logic [31:0] rd_data;

      dp_ram_ctrl #(
         .WIDTH(32),
         .DEPTH(D),
         .READ_LATENCY(L),
         .RDW_MODE(M)
      ) dut (
         .clk(clk),
         .rst(rst),
         .init_done(init_done),
         .wr_valid(wr_valid),
         .wr_ready(wr_ready),
         .wr_addr(wr_addr),
         .wr_data(wr_data),
         .wr_be(wr_be),
         .rd_valid(rd_valid),
         .rd_ready(rd_ready),
         .rd_addr(rd_addr),
         .rd_data(rd_data),
         .rd_data_valid(rd_data_valid),
         .addr_err(addr_err)
      );

      logic [31:0] ref_mem [64];
      int unsigned cyc    = 0;
      int unsigned since  = 0;
      bit          mready = 1'b0;
      bit          in_rst = 1'b0;
      exp_t        rq[$];
      int unsigned eq[$];
      logic [31:0] last_data = '0;
      logic [31:0] v;
      bit          wok;
      exp_t        e;
      bit          exp_err;

      // Reference model: acts on the requests present at each rising edge
      always @(posedge clk) begin
         cyc++;
         if (rst) begin
            in_rst = 1'b1;
            mready = 1'b0;
            since  = 0;
            rq.delete();
            eq.delete();
         end else begin
            in_rst = 1'b0;
            if (!mready) begin
               since++;
               if (since == D) begin
                  mready = 1'b1;
                  for (int unsigned i = 0; i < 64; i++) ref_mem[i] = '0;
               end
            end else begin
               wok = wr_valid && (32'(wr_addr) < D);
               if (rd_valid) begin
                  v = '0;
                  if (32'(rd_addr) < D) begin
                     v = ref_mem[rd_addr];
                     if (M == 0 && wok && wr_addr == rd_addr) v = merge(v, wr_data, wr_be);
                  end
                  rq.push_back('{cyc + L - 1, v});
               end
               if (wok) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_be);
               if ((wr_valid && 32'(wr_addr) >= D) || (rd_valid && 32'(rd_addr) >= D))
                  eq.push_back(cyc);
            end
         end
      end

      // Monitor: compares DUT outputs against the queued expectations
      always @(negedge clk) begin
         if (in_rst) begin
            last_data = '0;
            chk(g, "reset_outputs",
                64'({init_done, wr_ready, rd_ready, rd_data_valid, addr_err, rd_data}), 64'd0);
         end else begin
            chk(g, "ready_flags", 64'({init_done, wr_ready, rd_ready}), 64'({3{mready}}));
            exp_err = 1'b0;
            while (eq.size() > 0 && eq[0] <= cyc) begin
               if (eq[0] == cyc) exp_err = 1'b1;
               void'(eq.pop_front());
            end
            if (addr_err || exp_err) chk(g, "addr_err", 64'(addr_err), 64'(exp_err));
            if (rd_data_valid) begin
               if (rq.size() == 0) begin
                  chk(g, "rd_spurious", 64'(rd_data_valid), 64'd0);
               end else begin
                  e = rq.pop_front();
                  chk(g, "rd_latency", 64'(cyc), 64'(e.cyc));
                  chk(g, "rd_data", 64'(rd_data), 64'(e.data));
                  last_data = e.data;
               end
            end else begin
               if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                  e = rq.pop_front();
                  chk(g, "rd_missing", 64'(rd_data_valid), 64'd1);
               end
               chk(g, "rd_hold", 64'(rd_data), 64'(last_data));
            end
         end
      end
   end

   task automatic step(input bit wv, input logic [5:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input bit rv, input logic [5:0] ra);
      wr_valid = wv;
      wr_addr  = wa;
      wr_data  = wd;
      wr_be    = be;
      rd_valid = rv;
      rd_addr  = ra;
      @(negedge clk);
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) step(1'b0, 6'd0, 32'd0, 4'h0, 1'b0, 6'd0);
   endtask

   // Requests keep coming during the sweep; they must be ignored until ready
   task automatic wait_init();
      int unsigned n;
      n = 0;
      while (!(cfg[0].init_done && cfg[1].init_done && cfg[2].init_done) && n < 200) begin
         step(1'b1, 6'd9, $urandom, 4'hF, 1'b1, 6'd5);
         n++;
      end
      chk(99, "init_timeout", 64'(n < 200), 64'd1);
      idle(1);
   endtask

   task automatic do_reset(input int unsigned n);
      rst = 1'b1;
      repeat (n) step(1'b1, 6'd5, 32'h12345678, 4'hF, 1'b1, 6'd5);
      rst = 1'b0;
      wait_init();
   endtask

   initial begin
      logic [5:0] wa;
      logic [5:0] ra;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      wait_init();

      // Reset sweep clears a pre-written word
      step(1'b1, 6'd5, 32'hFFFFFFFF, 4'hF, 1'b0, 6'd0);
      do_reset(2);
      step(1'b0, 6'd0, 32'd0, 4'h0, 1'b1, 6'd5);

      // Byte enables
      step(1'b1, 6'd3, 32'h11223344, 4'hF, 1'b0, 6'd0);
      step(1'b1, 6'd3, 32'hAABBCCDD, 4'h5, 1'b0, 6'd0);
      step(1'b0, 6'd0, 32'd0, 4'h0, 1'b1, 6'd3);

      // Back-to-back reads
      for (int unsigned i = 0; i < 4; i++) step(1'b1, 6'(i), 32'hA0 + i, 4'hF, 1'b0, 6'd0);
      for (int unsigned i = 0; i < 4; i++) step(1'b0, 6'd0, 32'd0, 4'h0, 1'b1, 6'(i));

      // Read-during-write collision, then a plain re-read
      step(1'b1, 6'd7, 32'h0, 4'hF, 1'b0, 6'd0);
      step(1'b1, 6'd7, 32'hDEADBEEF, 4'h3, 1'b1, 6'd7);
      step(1'b0, 6'd0, 32'd0, 4'h0, 1'b1, 6'd7);

      // Out of range (for the 48-word instance), single and both ports at once
      step(1'b1, 6'd50, 32'h5555AAAA, 4'hF, 1'b0, 6'd0);
      step(1'b0, 6'd0, 32'd0, 4'h0, 1'b1, 6'd50);
      idle(1);
      step(1'b1, 6'd55, 32'h01010101, 4'hF, 1'b1, 6'd60);
      idle(3);

      // Reset one cycle after a read accept
      step(1'b0, 6'd0, 32'd0, 4'h0, 1'b1, 6'd1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      wait_init();

      // Random traffic with frequent same-address collisions
      for (int unsigned i = 0; i < 1500; i++) begin
         wa = 6'($urandom_range(0, 63));
         ra = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
         step($urandom_range(0, 3) != 0, wa, $urandom, 4'($urandom),
              $urandom_range(0, 3) != 0, ra);
      end

      // Full readback
      for (int unsigned i = 0; i < 64; i++) step(1'b0, 6'd0, 32'd0, 4'h0, 1'b1, 6'(i));
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #1000000;
      n_fails++;
      $display("FAIL global_timeout: got running expected finished");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
